sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

Message-schedule controller for the SHA-256 core. It accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream and buffers them in a 16-entry circular register file. It then sequences the 64 rounds, issuing W_t with its round index to the compression core over a second valid/ready stream. For t ≥ 16 it computes W_t on the fly with the σ0/σ1 rotate/shift datapath.

## Interface
- No parameters. Word width 32 and round count 64 are fixed constants in the package.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous abort: discards the current block and returns to LOAD.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts an input word.
- in_data  in  32  message word; the first word accepted is W0 = M[511:480].
- out_valid  out  1  W_t valid toward the compression core.
- out_ready  in  1  compression core accepts W_t.
- out_w  out  32  schedule word W_t.
- out_t  out  6  round index t, 0..63.
- out_k  out  32  round constant K_t. Present only with SHA256_SCHED_K_EN.
- block_done  out  1  one-cycle pulse after W63 is accepted.
- busy  out  1  high in RUN.

## Operation
- States: LOAD and RUN. Reset state is LOAD.
- **LOAD**
  - in_ready = 1 and out_valid = 0.
  - On in_valid && in_ready: buf[wcnt] <= in_data, then wcnt++.
  - On acceptance with wcnt == 15: go to RUN, set t = 0, set wcnt = 0.
- **RUN**
  - in_ready = 0 and out_valid = 1.
  - out_t = t.
  - out_w = buf[t] for t < 16.
  - out_w = σ1(buf[(t-2)&15]) + buf[(t-7)&15] + σ0(buf[(t-15)&15]) + buf[t&15] for t ≥ 16.
  - Arithmetic is modulo 2^32; carries out of bit 31 are discarded.
- **σ functions**
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - ROTR is a rotate right. SHR is a logical shift right with zero fill.
- **Handshake in RUN**
  - On out_valid && out_ready: buf[t&15] <= out_w, then t++.
  - The write is harmless for t < 16 because it writes the same value.
  - With out_ready low, out_w, out_t and out_k hold stable and no state changes.
- **End of block**
  - On acceptance of t == 63: block_done = 1 the next cycle, state returns to LOAD, t = 0.
- **clr**
  - Takes effect in the cycle it is sampled. Next state is LOAD with wcnt = 0 and t = 0. No block_done pulse.
  - clr has priority over any simultaneous input or output acceptance, and that transfer is dropped.
  - Buffer contents are not cleared.
- **Reset values**
  - State = LOAD; wcnt = 0; t = 0.
  - in_ready = 1 while reset is released. It is 0 while rst is asserted.
  - out_valid = 0, block_done = 0, busy = 0.
  - out_t = 0, out_w = 0.
  - buf is all zeros.

## Timing
- in_ready, out_valid, busy and block_done are decoded from registered state only. There is no combinational in→out path.
- out_w is combinational from buf and t, with one 4-input modular adder after the σ logic.
- Load-to-first-output latency: out_valid rises in the cycle after the 16th word is accepted.
- Throughput with out_ready held high: 16 load cycles plus 64 run cycles, giving one block per 80 cycles.
- in_ready rises the cycle after W63 is accepted, the same cycle block_done pulses. Back-to-back blocks need no gap cycle.
- Asynchronous rst mid-block: outputs go to reset values immediately and the partial block is lost.

## Configuration
- SHA256_SCHED_K_EN defined:
  - The out_k port exists and carries K_t for the current out_t, sourced from the package K table.
  - out_k is stable under backpressure.
  - out_k is 0 in LOAD.
- SHA256_SCHED_K_EN undefined:
  - The out_k port and the K table lookup are absent.
  - The compression core supplies K_t itself from out_t.

## Structure
- sha256_pkg holds:
  - SHA256_WORD_W = 32, SHA256_ROUNDS = 64.
  - The 64-entry K constant array.
  - The state enum {LOAD, RUN}.
  - Rotate helpers rotr(x, n) and shr(x, n).
- Sub-module sha256_sigma_small: combinational, taking inputs x15 and x2 and producing σ0(x15) and σ1(x2). It is reused by the later compression-side Σ block.

## Test plan
- Padded "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), out_ready held high → out_w at t=16 is 0x61626380, at t=17 is 0x000F0000, and t=63 matches the golden model; block_done pulses exactly once.
- Same block with out_ready toggled pseudo-randomly → identical W sequence; out_w and out_t stable on every stall cycle.
- Two blocks back-to-back with in_valid held high → second block W0 is accepted the cycle after the first block's W63; no gap cycle; both sequences are correct.
- clr asserted in RUN at t = 30 → next cycle LOAD, in_ready = 1, no block_done; a fresh block then produces the correct schedule.
- Async rst at LOAD with wcnt = 9 → outputs at reset values immediately; after release, 16 new words yield the correct schedule.
- With SHA256_SCHED_K_EN defined → out_k = 0x428A2F98 at t=0 and 0xC67178F2 at t=63; out_k = 0 in LOAD.

Source files
------------

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared constants, types and helpers for the SHA-256 message schedule and
// compression side.
//   SHA256_WORD_W / SHA256_ROUNDS : fixed word width and round count
//   T_W                           : width of the round index
//   K_TABLE                       : the 64 round constants K_t. The schedule
//                                   reads it only when SHA256_SCHED_K_EN is
//                                   defined.
//   sched_state_t                 : schedule controller states {LOAD, RUN}
//   rotr / shr                    : 32-bit rotate right / logical shift right
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int T_W           = $clog2(SHA256_ROUNDS);

  typedef logic [SHA256_WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  localparam word_t K_TABLE [SHA256_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Callers pass constant shift amounts in 1..31, so these reduce to wiring.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (SHA256_WORD_W - n));
  endfunction

  function automatic word_t shr(input word_t x, input int unsigned n);
    return x >> n;
  endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched_if
// Bundles the message-word input stream, the W_t output stream and the
// control/status lines of sha256_msg_sched.
//   clr                           : synchronous abort of the current block
//   in_valid / in_ready / in_data : 32-bit message words, W0 first
//   out_valid / out_ready         : W_t handshake toward the compression core
//   out_w / out_t                 : schedule word and its round index
//   out_k                         : K_t, present only with SHA256_SCHED_K_EN
//   block_done                    : one-cycle pulse after W63 is accepted
//   busy                          : high while rounds are being issued
// Modports: slave = the scheduler, master = whoever drives it.
// ---------------------------------------------------------------------------
interface sha256_msg_sched_if;
  import sha256_pkg::*;

  logic           clr;
  logic           in_valid;
  logic           in_ready;
  word_t          in_data;
  logic           out_valid;
  logic           out_ready;
  word_t          out_w;
  logic [T_W-1:0] out_t;
`ifdef SHA256_SCHED_K_EN
  word_t          out_k;
`endif
  logic           block_done;
  logic           busy;

`ifdef SHA256_SCHED_K_EN
  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_w, out_t, out_k, block_done, busy
  );
  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_w, out_t, out_k, block_done, busy
  );
`else
  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_w, out_t, block_done, busy
  );
  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_w, out_t, block_done, busy
  );
`endif

endinterface

// File: rtl/sha256_sigma_small.sv
// ---------------------------------------------------------------------------
// sha256_sigma_small
// Combinational small-sigma functions of the SHA-256 message schedule.
//   x15 : word W[t-15]  -> s0 = ROTR7 ^ ROTR18 ^ SHR3
//   x2  : word W[t-2]   -> s1 = ROTR17 ^ ROTR19 ^ SHR10
// ---------------------------------------------------------------------------
module sha256_sigma_small
  import sha256_pkg::*;
(
  input  word_t x15,
  input  word_t x2,
  output word_t s0,
  output word_t s1
);

  assign s0 = rotr(x15, 7)  ^ rotr(x15, 18) ^ shr(x15, 3);
  assign s1 = rotr(x2, 17)  ^ rotr(x2, 19)  ^ shr(x2, 10);

endmodule

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// SHA-256 message-schedule controller. LOAD takes 16 words into a circular
// 16-entry buffer. RUN issues W0..W63 with their round index. Words from W16
// onward are computed from the buffer and written back over the slot of
// W[t-16], which is no longer needed.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sha256_msg_sched_if.slave (streams, clr, block_done, busy)
// Optional: define SHA256_SCHED_K_EN to drive bus.out_k with K_t.
// ---------------------------------------------------------------------------
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sha256_msg_sched_if.slave bus
);

  sched_state_t   state_reg, state_next;
  logic [3:0]     wcnt_reg, wcnt_next;
  logic [T_W-1:0] t_reg, t_next;
  logic           done_reg, done_next;
  word_t          wbuf_reg [16];

  logic           load_st;
  logic           run_st;
  logic           wr_en;
  logic [3:0]     wr_addr;
  word_t          wr_data;

  logic [3:0]     t_lo;
  word_t          x2, x7, x15, x16;
  word_t          s0, s1;
  word_t          w_calc;

  assign load_st = (state_reg == LOAD);
  assign run_st  = (state_reg == RUN);

  // Ring-buffer taps. The 4-bit subtraction wraps, so (t-15)&15 is t+1.
  assign t_lo = t_reg[3:0];
  assign x2   = wbuf_reg[t_lo - 4'd2];
  assign x7   = wbuf_reg[t_lo - 4'd7];
  assign x15  = wbuf_reg[t_lo - 4'd15];
  assign x16  = wbuf_reg[t_lo];

  sha256_sigma_small u_sigma (
    .x15 (x15),
    .x2  (x2),
    .s0  (s0),
    .s1  (s1)
  );

  // For t < 16 the slot still holds the loaded message word.
  assign w_calc = (t_reg[T_W-1:4] == '0) ? x16 : (s1 + x7 + s0 + x16);

  // Status lines come from registered state only. in_ready is additionally
  // held low while rst is asserted.
  assign bus.in_ready   = load_st & ~rst;
  assign bus.out_valid  = run_st;
  assign bus.busy       = run_st;
  assign bus.block_done = done_reg;
  assign bus.out_t      = t_reg;
  assign bus.out_w      = run_st ? w_calc : '0;
`ifdef SHA256_SCHED_K_EN
  assign bus.out_k      = run_st ? K_TABLE[t_reg] : '0;
`endif

  // A single write port serves both phases. clr drops the transfer.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wcnt_reg;
    wr_data = bus.in_data;
    if (!bus.clr) begin
      if (load_st && bus.in_valid) begin
        wr_en = 1'b1;
      end else if (run_st && bus.out_ready) begin
        wr_en   = 1'b1;
        wr_addr = t_lo;
        wr_data = w_calc;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    t_next     = t_reg;
    done_next  = 1'b0;
    if (bus.clr) begin
      state_next = LOAD;
      wcnt_next  = '0;
      t_next     = '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (bus.in_valid) begin
            // wcnt wraps from 15 to 0 on its own.
            wcnt_next = wcnt_reg + 4'd1;
            if (wcnt_reg == 4'd15) begin
              state_next = RUN;
              t_next     = '0;
            end
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            // t wraps from 63 to 0 on its own.
            t_next = t_reg + 1'b1;
            if (t_reg == T_W'(SHA256_ROUNDS - 1)) begin
              state_next = LOAD;
              done_next  = 1'b1;
            end
          end
        end
        default: begin
          state_next = LOAD;
          wcnt_next  = '0;
          t_next     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
      wcnt_reg  <= '0;
      t_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      t_reg     <= t_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        wbuf_reg[i] <= '0;
      end
    end else if (wr_en) begin
      wbuf_reg[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_sched
// Directed bench for sha256_msg_sched. An independent schedule model pushes
// the expected W_t and t values into a queue when a block is loaded. Each
// accepted output pops one entry and compares it.
// ---------------------------------------------------------------------------
module tb_sha256_msg_sched;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_msg_sched_if bus ();

  sha256_msg_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_w_q [$];
  logic [5:0]  exp_t_q [$];
  logic [31:0] blk_abc [16];
  logic [31:0] blk_b   [16];
  logic [31:0] blk_c   [16];
  logic [31:0] blk_d   [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic push_expected(input logic [31:0] m [16]);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = m[i];
      else        w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
      exp_w_q.push_back(w[i]);
      exp_t_q.push_back(6'(i));
    end
  endtask

  // Drives 16 words, one per cycle, starting at a negedge. Leaves in_valid
  // asserted; the caller decides what follows.
  task automatic send_block(input logic [31:0] m [16], input bit push);
    if (push) push_expected(m);
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      chk("in_ready_load", 32'(bus.in_ready), 32'd1);
`ifdef SHA256_SCHED_K_EN
      chk("out_k_load", bus.out_k, 32'd0);
`endif
      $display("tb: in  word %0d = %08h", i, m[i]);
      @(posedge clk);
      @(negedge clk);
      chk("block_done_load", 32'(bus.block_done), 32'd0);
    end
    chk("first_out_valid", 32'(bus.out_valid), 32'd1);
    chk("busy_run", 32'(bus.busy), 32'd1);
  endtask

  // Consumes outputs until round stop_t is presented (not accepted) or,
  // with stop_t = 64, until W63 is taken and block_done is checked.
  task automatic drain(input bit rnd, input int stop_t, input bit abc);
    int          cycles = 0;
    bit          stalled = 1'b0;
    bit          last = 1'b0;
    logic [31:0] hold_w = '0;
    logic [5:0]  hold_t = '0;
    logic [31:0] ew;
    logic [5:0]  et;
    forever begin
      if (cycles > 3000) begin
        chk("drain_timeout", 32'd1, 32'd0);
        break;
      end
      cycles++;
      chk("out_valid_run", 32'(bus.out_valid), 32'd1);
      chk("in_ready_run", 32'(bus.in_ready), 32'd0);
      chk("block_done_run", 32'(bus.block_done), 32'd0);
      if (stalled) begin
        chk("stall_w", bus.out_w, hold_w);
        chk("stall_t", 32'(bus.out_t), 32'(hold_t));
      end
      if (int'(bus.out_t) == stop_t) begin
        bus.out_ready = 1'b0;
        break;
      end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_ready) begin
        if (exp_w_q.size() == 0) begin
          chk("queue_empty", 32'd1, 32'd0);
          break;
        end
        ew = exp_w_q.pop_front();
        et = exp_t_q.pop_front();
        chk("out_t", 32'(bus.out_t), 32'(et));
        chk("out_w", bus.out_w, ew);
        if (abc && et == 6'd16) chk("abc_w16", bus.out_w, 32'h61626380);
        if (abc && et == 6'd17) chk("abc_w17", bus.out_w, 32'h000f0000);
`ifdef SHA256_SCHED_K_EN
        if (et == 6'd0)  chk("out_k_t0", bus.out_k, 32'h428a2f98);
        if (et == 6'd63) chk("out_k_t63", bus.out_k, 32'hc67178f2);
`endif
        $display("tb: out t=%0d w=%08h", bus.out_t, bus.out_w);
        last = (et == 6'd63);
      end
      stalled = ~bus.out_ready;
      hold_w  = bus.out_w;
      hold_t  = bus.out_t;
      @(posedge clk);
      @(negedge clk);
      if (last) begin
        chk("block_done_pulse", 32'(bus.block_done), 32'd1);
        chk("in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("out_valid_after", 32'(bus.out_valid), 32'd0);
        break;
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      blk_abc[i] = '0;
      blk_b[i]   = $urandom;
      blk_c[i]   = 32'h01010101 * 32'(i + 1) ^ 32'h8badf00d;
      blk_d[i]   = $urandom;
    end
    blk_abc[0]  = 32'h61626380;
    blk_abc[15] = 32'h00000018;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rel_busy", 32'(bus.busy), 32'd0);
    chk("rel_block_done", 32'(bus.block_done), 32'd0);
    chk("rel_out_t", 32'(bus.out_t), 32'd0);
    chk("rel_out_w", bus.out_w, 32'd0);
    @(negedge clk);

    // "abc" block, out_ready held high; block_done must not repeat
    send_block(blk_abc, 1'b1);
    bus.in_valid = 1'b0;
    drain(1'b0, 64, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("block_done_once", 32'(bus.block_done), 32'd0);

    // Same block with random backpressure
    send_block(blk_abc, 1'b1);
    bus.in_valid = 1'b0;
    drain(1'b1, 64, 1'b1);

    // Back-to-back blocks with in_valid held high throughout RUN
    send_block(blk_b, 1'b1);
    bus.in_data = blk_c[0];
    drain(1'b0, 64, 1'b0);
    send_block(blk_c, 1'b1);
    bus.in_valid = 1'b0;
    drain(1'b0, 64, 1'b0);

    // clr at t = 30, with out_ready high in that cycle
    send_block(blk_abc, 1'b1);
    bus.in_valid = 1'b0;
    drain(1'b0, 30, 1'b0);
    bus.clr       = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_block_done", 32'(bus.block_done), 32'd0);
    chk("clr_out_t", 32'(bus.out_t), 32'd0);
    exp_w_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    chk("clr_block_done2", 32'(bus.block_done), 32'd0);
    send_block(blk_d, 1'b1);
    bus.in_valid = 1'b0;
    drain(1'b1, 64, 1'b0);

    // Async reset in LOAD after 9 words
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = blk_b[i];
      $display("tb: in  word %0d = %08h (partial)", i, blk_b[i]);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_block_done", 32'(bus.block_done), 32'd0);
    chk("arst_out_t", 32'(bus.out_t), 32'd0);
    chk("arst_out_w", bus.out_w, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    send_block(blk_c, 1'b1);
    bus.in_valid = 1'b0;
    drain(1'b0, 64, 1'b0);

    chk("queue_drained", 32'(exp_w_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
